// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states, oversampling
// constants and helpers for locating the error flags inside a FIFO entry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int TICK_MID      = 8;
  localparam int TICKS_PER_BIT = 16;

  // A FIFO entry is {framing_err, parity_err, data}.
  function automatic int pe_bit(input int data_w);
    return data_w;
  endfunction

  function automatic int fe_bit(input int data_w);
    return data_w + 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with fill level; empty reads return zero.
// Shared by the receive and transmit paths.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

  // A pop frees the slot a simultaneous push needs, so push is allowed at full.
  assign w_pop  = i_rd_en & ~o_empty;
  assign w_push = i_wr_en & (~o_full | w_pop);

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled majority-vote FSM feeding an FWFT FIFO of {fe, pe, data}.
// Define UART_RX_BREAK_DETECT_EN to add BREAK_DET and keep break frames out of the FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              RX,
  input  logic [12:0]       BAUD_VAL,
  input  logic              PARITY_EN,
  input  logic              ODD_N_EVEN,
  input  logic              TWO_STOP,
  input  logic              RD_EN,
  input  logic              CLR_OVF,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              PARITY_ERR,
  output logic              FRAMING_ERR,
  output logic              RXRDY,
  output logic [LVL_W-1:0]  FIFO_LEVEL,
  output logic              OVERFLOW,
  output logic              RX_BUSY
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic              BREAK_DET
`endif
);
  localparam int ENTRY_W = DATA_W + 2;
  localparam int FE_BIT  = fe_bit(DATA_W);
  localparam int PE_BIT  = pe_bit(DATA_W);
  localparam int TW      = $clog2(TICKS_PER_BIT);
  localparam logic [TW-1:0] TICK_S0   = TW'(TICK_MID - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(TICK_MID);
  localparam logic [TW-1:0] TICK_VOTE = TW'(TICK_MID + 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_W - 1);

  logic               r_rx_meta, r_rx_sync, r_rx_prev;
  logic [12:0]        r_baud_cnt;
  rx_state_e          r_state;
  logic               r_busy;
  logic [TW-1:0]      r_tick_cnt;
  logic [3:0]         r_bit_cnt;
  logic [1:0]         r_samp;
  logic [DATA_W-1:0]  r_shift;
  logic               r_par_en, r_odd, r_two_stop;
  logic               r_pe, r_fe;
  logic               r_push;
  logic [ENTRY_W-1:0] r_entry;
  logic               r_ovf;
  logic               w_fall, w_tick, w_vote, w_fe_now;
  logic [ENTRY_W-1:0] w_head;
  logic [LVL_W-1:0]   w_level;
  logic               w_full, w_empty;
`ifdef UART_RX_BREAK_DETECT_EN
  logic               r_par_bit;
  logic               r_break;
  logic               w_break;
`endif

  // NOTE: every clocked register uses non-blocking assignment so all flops sample together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) {r_rx_meta, r_rx_sync, r_rx_prev} <= 3'b111;
    else          {r_rx_meta, r_rx_sync, r_rx_prev} <= {RX, r_rx_meta, r_rx_sync};
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;
  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    r_baud_cnt <= BAUD_VAL;
    else if (w_tick) r_baud_cnt <= BAUD_VAL;
    else             r_baud_cnt <= r_baud_cnt - 1'b1;
  end

  assign w_vote   = maj3(r_samp[1], r_samp[0], r_rx_sync);
  assign w_fe_now = r_fe | ~w_vote;
`ifdef UART_RX_BREAK_DETECT_EN
  assign w_break  = ~|r_shift & ~(r_par_en & r_par_bit) & w_fe_now;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_odd      <= 1'b0;
      r_two_stop <= 1'b0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_push     <= 1'b0;
      r_entry    <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_par_bit  <= 1'b0;
      r_break    <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      if (r_rx_sync) r_break <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state    <= START;
            r_busy     <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_par_en   <= PARITY_EN;
            r_odd      <= ODD_N_EVEN;
            r_two_stop <= TWO_STOP;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
          end
        end
        default: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == TICK_S0 || r_tick_cnt == TICK_S1)
              r_samp <= {r_samp[0], r_rx_sync};
            if (r_tick_cnt == TICK_VOTE) begin
              case (r_state)
                START: begin
                  r_state <= w_vote ? IDLE : DATA;
                  r_busy  <= ~w_vote;
                end
                DATA: begin
                  r_shift   <= {w_vote, r_shift[DATA_W-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt <= '0;
                    r_state   <= r_par_en ? PARITY : STOP;
                  end
                end
                PARITY: begin
                  r_pe    <= (w_vote != (^r_shift ^ r_odd));
`ifdef UART_RX_BREAK_DETECT_EN
                  r_par_bit <= w_vote;
`endif
                  r_state <= STOP;
                end
                STOP: begin
                  if (r_two_stop && r_bit_cnt == '0) begin
                    r_fe      <= w_fe_now;
                    r_bit_cnt <= 4'd1;
                  end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_entry <= {w_fe_now, r_pe, r_shift};
`ifdef UART_RX_BREAK_DETECT_EN
                    if (w_break) r_break <= 1'b1;
                    else         r_push  <= 1'b1;
`else
                    r_push  <= 1'b1;
`endif
                  end
                end
                default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_wr_en   (r_push),
    .i_wr_data (r_entry),
    .i_rd_en   (RD_EN),
    .o_rd_data (w_head),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // A frame is lost only when it meets a full FIFO that is not being popped.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                         r_ovf <= 1'b0;
    else if (r_push && w_full && !RD_EN)  r_ovf <= 1'b1;
    else if (CLR_OVF)                     r_ovf <= 1'b0;
  end

  assign DATA_OUT    = w_head[DATA_W-1:0];
  assign PARITY_ERR  = w_head[PE_BIT];
  assign FRAMING_ERR = w_head[FE_BIT];
  assign RXRDY       = ~w_empty;
  assign FIFO_LEVEL  = w_level;
  assign OVERFLOW    = r_ovf;
  assign RX_BUSY     = r_busy;
`ifdef UART_RX_BREAK_DETECT_EN
  assign BREAK_DET   = r_break;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: drivers queue expected entries per frame and a
// negedge monitor compares the head against the queue on every accepted pop.
module tb_uart_rx_fifo;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_CLKS   = 16 * (3 + 1);

  logic              CLK        = 1'b0;
  logic              RESET_N    = 1'b0;
  logic              RX         = 1'b1;
  logic [12:0]       BAUD_VAL   = 13'd3;
  logic              PARITY_EN  = 1'b0;
  logic              ODD_N_EVEN = 1'b0;
  logic              TWO_STOP   = 1'b0;
  logic              RD_EN      = 1'b0;
  logic              CLR_OVF    = 1'b0;
  logic [DATA_W-1:0] DATA_OUT;
  logic              PARITY_ERR;
  logic              FRAMING_ERR;
  logic              RXRDY;
  logic [LVL_W-1:0]  FIFO_LEVEL;
  logic              OVERFLOW;
  logic              RX_BUSY;
`ifdef UART_RX_BREAK_DETECT_EN
  logic              BREAK_DET;
`endif

  typedef struct packed {
    logic              fe;
    logic              pe;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t exp_q[$];
  entry_t mon_e;
  int     n_checks = 0;
  int     n_fail   = 0;

  uart_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .RX          (RX),
    .BAUD_VAL    (BAUD_VAL),
    .PARITY_EN   (PARITY_EN),
    .ODD_N_EVEN  (ODD_N_EVEN),
    .TWO_STOP    (TWO_STOP),
    .RD_EN       (RD_EN),
    .CLR_OVF     (CLR_OVF),
    .DATA_OUT    (DATA_OUT),
    .PARITY_ERR  (PARITY_ERR),
    .FRAMING_ERR (FRAMING_ERR),
    .RXRDY       (RXRDY),
    .FIFO_LEVEL  (FIFO_LEVEL),
    .OVERFLOW    (OVERFLOW),
    .RX_BUSY     (RX_BUSY)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .BREAK_DET   (BREAK_DET)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want completion within 2 ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic fe, input logic pe, input logic [DATA_W-1:0] d);
    entry_t e;
    e.fe   = fe;
    e.pe   = pe;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: inputs change just after posedge, so negedge sees what the DUT will act on.
  always @(negedge CLK) begin
    if (RESET_N && RD_EN && RXRDY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, want no entry", DATA_OUT);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_data", DATA_OUT, mon_e.data);
        check("pop_parity_err", PARITY_ERR, mon_e.pe);
        check("pop_framing_err", FRAMING_ERR, mon_e.fe);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    step(BIT_CLKS);
  endtask

  task automatic pop();
    RD_EN = 1'b1;
    step(1);
    RD_EN = 1'b0;
  endtask

  // mode 1: check RXRDY rises exactly one clock after the stop vote; mode 2: pop on the push cycle.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par_bit,
                            input logic stop1, input logic stop2, input int mode);
    int used;
    bit done;
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    if (PARITY_EN) send_bit(par_bit);
    if (TWO_STOP) begin
      send_bit(stop1);
      RX = stop2;
    end else begin
      RX = stop1;
    end
    used = 0;
    done = 1'b0;
    while (!done && used < BIT_CLKS) begin
      step(1);
      used++;
      done = !RX_BUSY;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: got RX_BUSY=1 after %0d clocks, want 0", used);
    end else if (mode == 1) begin
      check("rxrdy_at_vote", RXRDY, 0);
      step(1);
      used++;
      check("rxrdy_vote_plus1", RXRDY, 1);
    end else if (mode == 2) begin
      RD_EN = 1'b1;
      step(1);
      used++;
      RD_EN = 1'b0;
    end
    if (used < BIT_CLKS) step(BIT_CLKS - used);
    RX = 1'b1;
    step(16);
  endtask

  initial begin
    int  cnt;
    bit  seen;

    step(2);
    check("rst_data_out", DATA_OUT, 0);
    check("rst_parity_err", PARITY_ERR, 0);
    check("rst_framing_err", FRAMING_ERR, 0);
    check("rst_rxrdy", RXRDY, 0);
    check("rst_level", FIFO_LEVEL, 0);
    check("rst_overflow", OVERFLOW, 0);
    check("rst_busy", RX_BUSY, 0);
    RESET_N = 1'b1;
    step(8);

    // Plain 8N1 frame
    expect_entry(1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1);
    check("t1_level", FIFO_LEVEL, 1);
    check("t1_head", DATA_OUT, 8'hA5);
    check("t1_pe", PARITY_ERR, 0);
    check("t1_fe", FRAMING_ERR, 0);
    pop();
    check("t1_rxrdy_after_pop", RXRDY, 0);
    check("t1_data_after_pop", DATA_OUT, 0);

    // Parity: odd 0x03 with bit 0 is wrong; odd 0x07 with 0 and even 0x07 with 1 are right
    PARITY_EN  = 1'b1;
    ODD_N_EVEN = 1'b1;
    expect_entry(1'b0, 1'b1, 8'h03);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, 0);
    expect_entry(1'b0, 1'b0, 8'h07);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 0);
    ODD_N_EVEN = 1'b0;
    expect_entry(1'b0, 1'b0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0);
    check("t2_level", FIFO_LEVEL, 3);
    check("t2_head", DATA_OUT, 8'h03);
    check("t2_head_pe", PARITY_ERR, 1);
    repeat (3) pop();
    check("t2_rxrdy_empty", RXRDY, 0);
    check("t2_data_empty", DATA_OUT, 0);

    // Two stop bits, second one low, then a clean frame
    PARITY_EN = 1'b0;
    TWO_STOP  = 1'b1;
    expect_entry(1'b1, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
    expect_entry(1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 0);
    check("t3_level", FIFO_LEVEL, 2);
    check("t3_head_fe", FRAMING_ERR, 1);
    repeat (2) pop();
    TWO_STOP = 1'b0;

    // Two-clock glitch: FSM starts, rejects at the start vote, writes nothing
    RX = 1'b0;
    step(2);
    RX = 1'b1;
    seen = 1'b0;
    for (cnt = 0; cnt < 6 && !seen; cnt++) begin
      step(1);
      seen = RX_BUSY;
    end
    check("t4_busy_rise", seen, 1);
    seen = 1'b0;
    for (cnt = 0; cnt < 48 && !seen; cnt++) begin
      step(1);
      seen = !RX_BUSY;
    end
    check("t4_busy_fall", seen, 1);
    check("t4_level", FIFO_LEVEL, 0);
    check("t4_rxrdy", RXRDY, 0);

    // Overflow: four stored, fifth dropped
    expect_entry(1'b0, 1'b0, 8'h11);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 0);
    expect_entry(1'b0, 1'b0, 8'h22);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 0);
    expect_entry(1'b0, 1'b0, 8'h33);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, 0);
    expect_entry(1'b0, 1'b0, 8'h44);
    send_frame(8'h44, 1'b0, 1'b1, 1'b1, 0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 0);
    check("t5_level_full", FIFO_LEVEL, 4);
    check("t5_overflow_set", OVERFLOW, 1);
    check("t5_head_first", DATA_OUT, 8'h11);
    CLR_OVF = 1'b1;
    step(1);
    CLR_OVF = 1'b0;
    check("t5_overflow_clr", OVERFLOW, 0);
    expect_entry(1'b0, 1'b0, 8'h66);
    send_frame(8'h66, 1'b0, 1'b1, 1'b1, 2);
    check("t5_level_pushpop", FIFO_LEVEL, 4);
    check("t5_overflow_pushpop", OVERFLOW, 0);
    check("t5_head_second", DATA_OUT, 8'h22);
    repeat (4) pop();
    check("t5_rxrdy_empty", RXRDY, 0);
    pop();
    check("t5_level_pop_empty", FIFO_LEVEL, 0);

    // Reset mid-DATA with one entry already stored
    send_frame(8'h77, 1'b0, 1'b1, 1'b1, 0);
    check("t6_level_before", FIFO_LEVEL, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t6_busy_mid", RX_BUSY, 1);
    RESET_N = 1'b0;
    #1;
    check("t6_rst_data", DATA_OUT, 0);
    check("t6_rst_pe", PARITY_ERR, 0);
    check("t6_rst_fe", FRAMING_ERR, 0);
    check("t6_rst_rxrdy", RXRDY, 0);
    check("t6_rst_level", FIFO_LEVEL, 0);
    check("t6_rst_overflow", OVERFLOW, 0);
    check("t6_rst_busy", RX_BUSY, 0);
    RX = 1'b1;
    step(3);
    RESET_N = 1'b1;
    step(20);
    expect_entry(1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 0);
    check("t6_level_after", FIFO_LEVEL, 1);
    check("t6_head_after", DATA_OUT, 8'h81);
    pop();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
